// File: rtl/instr_cycle_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit micro with wait-state handshakes on both memories,
// CALL/RET through a return-address stack, a terminal HALT state and a sticky ERROR state.
module instr_cycle_ctrl #(
    parameter int unsigned INST_ADDR_WIDTH = 8,
    parameter int unsigned INST_DATA_WIDTH = 8,
    parameter int unsigned MEM_ADDR_WIDTH  = 8,
    parameter int unsigned MEM_DATA_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH     = 4,
    localparam int unsigned SP_WIDTH       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       arst,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr,
    output logic                       inst_req,
    input  logic                       inst_ack,
    input  logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
    output logic                       mem_req,
    output logic                       mem_WE,
    input  logic                       mem_ack,
    input  logic [MEM_DATA_WIDTH-1:0]  mem_data_i,
    output logic [MEM_DATA_WIDTH-1:0]  mem_data_o,
    output logic                       Exec,
    input  logic [3:0]                 Flags,
    input  logic [MEM_DATA_WIDTH-1:0]  AR,
    output logic [INST_DATA_WIDTH-1:0] IR,
    output logic [INST_DATA_WIDTH-1:0] IBR,
    output logic [MEM_DATA_WIDTH-1:0]  MBR,
    output logic [SP_WIDTH-1:0]        sp,
    output logic                       halted,
    output logic                       error
);

    localparam logic [7:0] OpNop    = 8'h00;
    localparam logic [7:0] OpLoadX  = 8'h04;
    localparam logic [7:0] OpStoreX = 8'h05;
    localparam logic [7:0] OpStoreI = 8'h06;
    localparam logic [7:0] OpJmp    = 8'h10;
    localparam logic [7:0] OpJz     = 8'h11;
    localparam logic [7:0] OpJc     = 8'h12;
    localparam logic [7:0] OpJn     = 8'h13;
    localparam logic [7:0] OpJv     = 8'h14;
    localparam logic [7:0] OpCall   = 8'h15;
    localparam logic [7:0] OpRet    = 8'h16;
    localparam logic [7:0] OpHalt   = 8'hFF;

    localparam int unsigned FlagZero  = 0;
    localparam int unsigned FlagCarry = 1;
    localparam int unsigned FlagNeg   = 2;
    localparam int unsigned FlagOv    = 3;

    localparam int unsigned IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_WIDTH-1:0] SpFull = SP_WIDTH'(STACK_DEPTH);

    typedef enum logic [2:0] {
        StFetch    = 3'd0,
        StDecode   = 3'd1,
        StReadMem  = 3'd2,
        StWriteMem = 3'd3,
        StExecute  = 3'd4,
        StHalt     = 3'd5,
        StError    = 3'd6
    } state_e;

    state_e                     r_state, w_state_nxt;
    logic [INST_ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [INST_DATA_WIDTH-1:0] r_ir, w_ir_nxt;
    logic [INST_DATA_WIDTH-1:0] r_ibr, w_ibr_nxt;
    logic [MEM_DATA_WIDTH-1:0]  r_mbr, w_mbr_nxt;
    logic [MEM_ADDR_WIDTH-1:0]  r_mar, w_mar_nxt;
    logic [MEM_DATA_WIDTH-1:0]  r_mbr_o, w_mbr_o_nxt;
    logic [SP_WIDTH-1:0]        r_sp, w_sp_nxt;
    logic [INST_ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic                       w_stack_wr;
    logic [7:0]                 w_opcode;
    logic                       w_mem_src;
    logic [INST_ADDR_WIDTH-1:0] w_offset;
    logic [INST_ADDR_WIDTH-1:0] w_target;
    logic [IDX_WIDTH-1:0]       w_push_idx;
    logic [IDX_WIDTH-1:0]       w_pop_idx;

    assign w_opcode   = r_ir[7:0];
    // ALU ops with a memory source operand: opcode 01_0000xx or 10_0000xx
    assign w_mem_src  = (^r_ir[7:6]) && ~|r_ir[5:2];
    assign w_offset   = INST_ADDR_WIDTH'({{INST_ADDR_WIDTH{r_ibr[7]}}, r_ibr[7:0]});
    assign w_target   = r_pc + w_offset;
    assign w_push_idx = IDX_WIDTH'(r_sp);
    assign w_pop_idx  = IDX_WIDTH'(r_sp - SP_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_ibr_nxt   = r_ibr;
        w_mbr_nxt   = r_mbr;
        w_mar_nxt   = r_mar;
        w_mbr_o_nxt = r_mbr_o;
        w_sp_nxt    = r_sp;
        w_stack_wr  = 1'b0;
        inst_req    = 1'b0;
        mem_req     = 1'b0;
        mem_WE      = 1'b0;
        Exec        = 1'b0;
        halted      = 1'b0;
        error       = 1'b0;

        case (r_state)
            StFetch: begin
                inst_req = 1'b1;
                if (inst_ack) begin
                    w_ir_nxt    = inst_data;
                    w_pc_nxt    = r_pc + INST_ADDR_WIDTH'(1);
                    w_state_nxt = StDecode;
                end
            end
            StDecode: begin
                inst_req = 1'b1;
                if (inst_ack) begin
                    w_ibr_nxt = inst_data;
                    w_pc_nxt  = r_pc + INST_ADDR_WIDTH'(1);
                    if (w_opcode == OpStoreX) begin
                        w_mar_nxt   = MEM_ADDR_WIDTH'(inst_data);
                        w_mbr_o_nxt = AR;
                        w_state_nxt = StWriteMem;
                    end else if (w_opcode == OpStoreI) begin
                        w_mar_nxt   = MEM_ADDR_WIDTH'(AR);
                        w_mbr_o_nxt = MEM_DATA_WIDTH'(inst_data);
                        w_state_nxt = StWriteMem;
                    end else if (w_opcode == OpLoadX || w_mem_src) begin
                        w_mar_nxt   = MEM_ADDR_WIDTH'(inst_data);
                        w_state_nxt = StReadMem;
                    end else if (w_opcode == OpHalt) begin
                        w_state_nxt = StHalt;
                    end else begin
                        w_state_nxt = StExecute;
                    end
                end
            end
            StReadMem: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_mbr_nxt   = mem_data_i;
                    w_state_nxt = StExecute;
                end
            end
            StWriteMem: begin
                mem_req = 1'b1;
                mem_WE  = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = StExecute;
                end
            end
            StExecute: begin
                Exec        = 1'b1;
                w_state_nxt = StFetch;
                case (w_opcode)
                    OpJmp: w_pc_nxt = w_target;
                    OpJz:  if (Flags[FlagZero])  w_pc_nxt = w_target;
                    OpJc:  if (Flags[FlagCarry]) w_pc_nxt = w_target;
                    OpJn:  if (Flags[FlagNeg])   w_pc_nxt = w_target;
                    OpJv:  if (Flags[FlagOv])    w_pc_nxt = w_target;
                    OpCall: begin
                        if (r_sp == SpFull) begin
                            w_state_nxt = StError;
                        end else begin
                            w_stack_wr = 1'b1;
                            w_sp_nxt   = r_sp + SP_WIDTH'(1);
                            w_pc_nxt   = w_target;
                        end
                    end
                    OpRet: begin
                        if (r_sp == '0) begin
                            w_state_nxt = StError;
                        end else begin
                            w_pc_nxt = r_stack[w_pop_idx];
                            w_sp_nxt = r_sp - SP_WIDTH'(1);
                        end
                    end
                    OpNop:   ;
                    default: ;
                endcase
            end
            StHalt: begin
                halted = 1'b1;
            end
            StError: begin
                error = 1'b1;
            end
            default: begin
                w_state_nxt = StError;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_ibr   <= '0;
            r_mbr   <= '0;
            r_mar   <= '0;
            r_mbr_o <= '0;
            r_sp    <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_ibr   <= w_ibr_nxt;
            r_mbr   <= w_mbr_nxt;
            r_mar   <= w_mar_nxt;
            r_mbr_o <= w_mbr_o_nxt;
            r_sp    <= w_sp_nxt;
            // Return address is the PC after the operand fetch
            if (w_stack_wr) begin
                r_stack[w_push_idx] <= r_pc;
            end
        end
    end

    assign inst_addr  = r_pc;
    assign mem_addr   = r_mar;
    assign mem_data_o = r_mbr_o;
    assign IR         = r_ir;
    assign IBR        = r_ibr;
    assign MBR        = r_mbr;
    assign sp         = r_sp;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Self-checking bench for instr_cycle_ctrl: instruction ROM and data RAM models, with a
// scoreboard of expected data-memory writes popped as the DUT performs them.
module tb_instr_cycle_ctrl;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LOADX  = 8'h04;
    localparam logic [7:0] OP_STOREX = 8'h05;
    localparam logic [7:0] OP_STOREI = 8'h06;
    localparam logic [7:0] OP_JMP    = 8'h10;
    localparam logic [7:0] OP_JZ     = 8'h11;
    localparam logic [7:0] OP_JC     = 8'h12;
    localparam logic [7:0] OP_JN     = 8'h13;
    localparam logic [7:0] OP_JV     = 8'h14;
    localparam logic [7:0] OP_CALL   = 8'h15;
    localparam logic [7:0] OP_RET    = 8'h16;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       inst_ack = 1'b0;
    logic       mem_ack = 1'b0;
    logic [3:0] Flags = 4'h0;
    logic [7:0] AR = 8'h00;
    logic [7:0] inst_addr, inst_data, mem_addr, mem_data_i, mem_data_o, IR, IBR, MBR;
    logic       inst_req, mem_req, mem_WE, Exec, halted, error;
    logic [1:0] sp;

    logic [7:0]  rom [256];
    logic [7:0]  ram [256];
    logic [15:0] exp_wr_q [$];
    logic [15:0] exp_wr;
    int total = 0;
    int bad = 0;
    int wr_count = 0;

    always #5 clk = ~clk;

    assign inst_data  = rom[inst_addr];
    assign mem_data_i = ram[mem_addr];

    instr_cycle_ctrl #(
        .INST_ADDR_WIDTH(8),
        .INST_DATA_WIDTH(8),
        .MEM_ADDR_WIDTH (8),
        .MEM_DATA_WIDTH (8),
        .STACK_DEPTH    (2)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .inst_addr (inst_addr),
        .inst_req  (inst_req),
        .inst_ack  (inst_ack),
        .inst_data (inst_data),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_WE    (mem_WE),
        .mem_ack   (mem_ack),
        .mem_data_i(mem_data_i),
        .mem_data_o(mem_data_o),
        .Exec      (Exec),
        .Flags     (Flags),
        .AR        (AR),
        .IR        (IR),
        .IBR       (IBR),
        .MBR       (MBR),
        .sp        (sp),
        .halted    (halted),
        .error     (error)
    );

    // Data RAM write port and write scoreboard; a write completes on the next rising edge
    always @(negedge clk) begin
        #3;
        if (!arst && mem_req && mem_WE && mem_ack) begin
            total++;
            if (exp_wr_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                         mem_addr, mem_data_o);
            end else begin
                exp_wr = exp_wr_q.pop_front();
                if ({mem_addr, mem_data_o} !== exp_wr) begin
                    bad++;
                    $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_data_o, exp_wr[15:8], exp_wr[7:0]);
                end
            end
            ram[mem_addr] = mem_data_o;
            wr_count++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = OP_HALT;
            ram[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst     = 1'b1;
        inst_ack = 1'b0;
        mem_ack  = 1'b0;
        exp_wr_q.delete();
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        total++;
        if ({inst_req, mem_req, mem_WE, Exec, halted, error} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, required 100000",
                     {inst_req, mem_req, mem_WE, Exec, halted, error});
        end
        total++;
        if ({inst_addr, IR, IBR, MBR, mem_addr, mem_data_o, sp} !== 50'h0) begin
            bad++;
            $display("FAIL reset_regs: got pc=%h ir=%h ibr=%h mbr=%h mar=%h mbro=%h sp=%0d, required 0",
                     inst_addr, IR, IBR, MBR, mem_addr, mem_data_o, sp);
        end
        // A data ack while fetching is not requested and must be ignored
        mem_ack = 1'b1;
        tick(3);
        total++;
        if ({inst_req, mem_req, inst_addr, IR} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
            bad++;
            $display("FAIL fetch_wait: got req=%b mreq=%b pc=%h ir=%h, required 1 0 00 00",
                     inst_req, mem_req, inst_addr, IR);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_load();
        clear_mem();
        rom[0] = OP_LOADX; rom[1] = 8'h10; ram[8'h10] = 8'h5A;
        do_reset();
        inst_ack = 1'b1;
        mem_ack  = 1'b1;
        tick(2);
        total++;
        if ({mem_req, mem_WE, mem_addr, Exec} !== {1'b1, 1'b0, 8'h10, 1'b0}) begin
            bad++;
            $display("FAIL load_read: got mreq=%b we=%b addr=%h exec=%b, required 1 0 10 0",
                     mem_req, mem_WE, mem_addr, Exec);
        end
        tick(1);
        total++;
        if ({Exec, MBR, inst_addr} !== {1'b1, 8'h5A, 8'h02}) begin
            bad++;
            $display("FAIL load_exec: got exec=%b mbr=%h pc=%h, required 1 5a 02",
                     Exec, MBR, inst_addr);
        end
        tick(1);
        total++;
        if ({Exec, inst_req} !== 2'b01) begin
            bad++;
            $display("FAIL exec_one_cycle: got exec=%b req=%b, required 0 1", Exec, inst_req);
        end
        tick(2);
        total++;
        if ({halted, inst_req, error, inst_addr} !== {1'b1, 1'b0, 1'b0, 8'h04}) begin
            bad++;
            $display("FAIL halt_enter: got halted=%b req=%b err=%b pc=%h, required 1 0 0 04",
                     halted, inst_req, error, inst_addr);
        end
        tick(4);
        total++;
        if ({halted, inst_addr} !== {1'b1, 8'h04}) begin
            bad++;
            $display("FAIL halt_stay: got halted=%b pc=%h, required 1 04", halted, inst_addr);
        end
    endtask

    task automatic test_store_wait();
        int w0;
        clear_mem();
        rom[0] = OP_STOREI; rom[1] = 8'h33;
        AR = 8'h20;
        do_reset();
        exp_wr_q.push_back({8'h20, 8'h33});
        w0 = wr_count;
        inst_ack = 1'b1;
        tick(2);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_ack = 1'b1;
            total++;
            if ({mem_req, mem_WE, mem_addr, mem_data_o, Exec} !==
                {1'b1, 1'b1, 8'h20, 8'h33, 1'b0}) begin
                bad++;
                $display("FAIL store_hold[%0d]: got mreq=%b we=%b addr=%h data=%h exec=%b, required 1 1 20 33 0",
                         c, mem_req, mem_WE, mem_addr, mem_data_o, Exec);
            end
            if (c < 3) tick(1);
        end
        tick(1);
        mem_ack = 1'b0;
        total++;
        if ({Exec, mem_req, mem_WE} !== 3'b100) begin
            bad++;
            $display("FAIL store_exec: got exec=%b mreq=%b we=%b, required 1 0 0",
                     Exec, mem_req, mem_WE);
        end
        total++;
        if (wr_count - w0 != 1 || exp_wr_q.size() != 0 || ram[8'h20] !== 8'h33) begin
            bad++;
            $display("FAIL store_count: got writes=%0d pending=%0d ram=%h, required 1 0 33",
                     wr_count - w0, exp_wr_q.size(), ram[8'h20]);
        end
    endtask

    task automatic test_branch();
        logic [7:0] t_op [8];
        logic [7:0] t_off [8];
        logic [3:0] t_early [8];
        logic [3:0] t_exec [8];
        logic [7:0] t_pc [8];
        t_op[0] = OP_JZ;  t_off[0] = 8'hFE; t_early[0] = 4'b0001; t_exec[0] = 4'b0001; t_pc[0] = 8'h00;
        t_op[1] = OP_JZ;  t_off[1] = 8'hFE; t_early[1] = 4'b0001; t_exec[1] = 4'b0000; t_pc[1] = 8'h02;
        t_op[2] = OP_JC;  t_off[2] = 8'h10; t_early[2] = 4'b0000; t_exec[2] = 4'b0010; t_pc[2] = 8'h12;
        t_op[3] = OP_JC;  t_off[3] = 8'h10; t_early[3] = 4'b0010; t_exec[3] = 4'b1101; t_pc[3] = 8'h02;
        t_op[4] = OP_JN;  t_off[4] = 8'h05; t_early[4] = 4'b0000; t_exec[4] = 4'b0100; t_pc[4] = 8'h07;
        t_op[5] = OP_JV;  t_off[5] = 8'h80; t_early[5] = 4'b0000; t_exec[5] = 4'b1000; t_pc[5] = 8'h82;
        t_op[6] = OP_JMP; t_off[6] = 8'hFF; t_early[6] = 4'b0000; t_exec[6] = 4'b0000; t_pc[6] = 8'h01;
        t_op[7] = OP_JV;  t_off[7] = 8'h7F; t_early[7] = 4'b1000; t_exec[7] = 4'b0111; t_pc[7] = 8'h02;
        for (int k = 0; k < 8; k++) begin
            clear_mem();
            rom[0] = t_op[k]; rom[1] = t_off[k];
            do_reset();
            Flags    = t_early[k];
            inst_ack = 1'b1;
            tick(2);
            total++;
            if (Exec !== 1'b1) begin
                bad++;
                $display("FAIL branch_exec[%0d]: got exec=%b, required 1", k, Exec);
            end
            Flags    = t_exec[k];
            inst_ack = 1'b0;
            tick(1);
            total++;
            if ({inst_addr, Exec, inst_req} !== {t_pc[k], 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL branch_pc[%0d]: got pc=%h exec=%b req=%b, required pc=%h 0 1",
                         k, inst_addr, Exec, inst_req, t_pc[k]);
            end
        end
        Flags = 4'h0;
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        rom[0] = OP_JMP; rom[1] = 8'hFD; rom[8'hFF] = OP_NOP;
        do_reset();
        inst_ack = 1'b1;
        tick(3);
        total++;
        if (inst_addr !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_target: got pc=%h, required ff", inst_addr);
        end
        tick(1);
        total++;
        if ({inst_addr, IR} !== {8'h00, OP_NOP}) begin
            bad++;
            $display("FAIL wrap_pc: got pc=%h ir=%h, required 00 00", inst_addr, IR);
        end
        tick(2);
        inst_ack = 1'b0;
        total++;
        if (inst_addr !== 8'h01) begin
            bad++;
            $display("FAIL wrap_nop: got pc=%h, required 01", inst_addr);
        end
    endtask

    task automatic test_stack_errors();
        clear_mem();
        rom[0] = OP_CALL; rom[1] = 8'h02;
        rom[4] = OP_CALL; rom[5] = 8'h02;
        rom[8] = OP_CALL; rom[9] = 8'h02;
        do_reset();
        inst_ack = 1'b1;
        tick(3);
        total++;
        if ({sp, inst_addr} !== {2'd1, 8'h04}) begin
            bad++;
            $display("FAIL call1: got sp=%0d pc=%h, required 1 04", sp, inst_addr);
        end
        tick(3);
        total++;
        if ({sp, inst_addr} !== {2'd2, 8'h08}) begin
            bad++;
            $display("FAIL call2: got sp=%0d pc=%h, required 2 08", sp, inst_addr);
        end
        tick(3);
        total++;
        if ({error, halted, sp, inst_addr, inst_req, mem_req} !==
            {1'b1, 1'b0, 2'd2, 8'h0A, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL overflow: got err=%b halted=%b sp=%0d pc=%h req=%b mreq=%b, required 1 0 2 0a 0 0",
                     error, halted, sp, inst_addr, inst_req, mem_req);
        end
        tick(3);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL error_sticky: got err=%b, required 1", error);
        end
        clear_mem();
        rom[0] = OP_RET; rom[1] = 8'h00;
        do_reset();
        inst_ack = 1'b1;
        tick(3);
        total++;
        if ({error, halted, sp} !== {1'b1, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL underflow: got err=%b halted=%b sp=%0d, required 1 0 0",
                     error, halted, sp);
        end
    endtask

    task automatic test_call_ret();
        clear_mem();
        rom[0] = OP_CALL; rom[1] = 8'h04;
        rom[6] = OP_RET;  rom[7] = 8'h00;
        do_reset();
        inst_ack = 1'b1;
        tick(2);
        total++;
        if (Exec !== 1'b1) begin
            bad++;
            $display("FAIL call_exec: got exec=%b, required 1", Exec);
        end
        tick(1);
        total++;
        if ({sp, inst_addr} !== {2'd1, 8'h06}) begin
            bad++;
            $display("FAIL call_target: got sp=%0d pc=%h, required 1 06", sp, inst_addr);
        end
        tick(3);
        total++;
        if ({sp, inst_addr, error} !== {2'd0, 8'h02, 1'b0}) begin
            bad++;
            $display("FAIL ret_pc: got sp=%0d pc=%h err=%b, required 0 02 0", sp, inst_addr, error);
        end
        tick(2);
        total++;
        if ({halted, inst_addr} !== {1'b1, 8'h04}) begin
            bad++;
            $display("FAIL ret_halt: got halted=%b pc=%h, required 1 04", halted, inst_addr);
        end
        do_reset();
        total++;
        if ({halted, inst_req, inst_addr} !== {1'b0, 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL halt_reset: got halted=%b req=%b pc=%h, required 0 1 00",
                     halted, inst_req, inst_addr);
        end
    endtask

    task automatic test_reset_midwait();
        clear_mem();
        rom[0] = OP_LOADX; rom[1] = 8'h10; ram[8'h10] = 8'h5A;
        do_reset();
        inst_ack = 1'b1;
        tick(3);
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 8'h10}) begin
            bad++;
            $display("FAIL read_wait: got mreq=%b addr=%h, required 1 10", mem_req, mem_addr);
        end
        // Reset and a data ack land on the same edge; reset must win
        arst    = 1'b1;
        mem_ack = 1'b1;
        tick(1);
        arst     = 1'b0;
        mem_ack  = 1'b0;
        inst_ack = 1'b0;
        total++;
        if ({inst_req, mem_req, Exec, inst_addr, sp, MBR, IR} !==
            {1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 8'h00}) begin
            bad++;
            $display("FAIL reset_midwait: got req=%b mreq=%b exec=%b pc=%h sp=%0d mbr=%h ir=%h, required 1 0 0 00 0 00 00",
                     inst_req, mem_req, Exec, inst_addr, sp, MBR, IR);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        int execs;
        clear_mem();
        rom[0] = OP_STOREX; rom[1] = 8'h40;
        rom[2] = OP_STOREI; rom[3] = 8'h99;
        rom[4] = OP_LOADX;  rom[5] = 8'h40;
        rom[6] = 8'h41;     rom[7] = 8'h77;
        AR = 8'h77;
        do_reset();
        exp_wr_q.push_back({8'h40, 8'h77});
        exp_wr_q.push_back({8'h77, 8'h99});
        w0 = wr_count;
        execs = 0;
        inst_ack = 1'b1;
        mem_ack  = 1'b1;
        for (int c = 0; c < 60 && !halted; c++) begin
            tick(1);
            if (Exec) execs++;
        end
        inst_ack = 1'b0;
        mem_ack  = 1'b0;
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL b2b_timeout: got halted=%b, required 1 within 60 cycles", halted);
        end
        total++;
        if (execs != 4 || wr_count - w0 != 2 || exp_wr_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_counts: got execs=%0d writes=%0d pending=%0d, required 4 2 0",
                     execs, wr_count - w0, exp_wr_q.size());
        end
        total++;
        if ({MBR, inst_addr} !== {8'h99, 8'h0A}) begin
            bad++;
            $display("FAIL b2b_state: got mbr=%h pc=%h, required 99 0a", MBR, inst_addr);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_wait();
        test_branch();
        test_pc_wrap();
        test_stack_errors();
        test_call_ret();
        test_reset_midwait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end

endmodule
